// File: rtl/vect_serializer.sv
// Parallel-to-serial converter: accepts an N-bit word and emits it MSB first,
// one bit per cycle, with registered ser_out/ser_valid/ser_last.
// Optional feature: define VECT_SERIALIZER_PARITY_EN to append an even-parity
// bit after bit 0. With it, the frame is N+1 cycles and ser_last marks the parity bit.
module vect_serializer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_last,
    output logic         busy
);

    // Reject unsupported widths at elaboration time
    generate
        if (N < 1 || N > 8) begin : g_bad_n
            $error("Parameter N has an invalid value of %0d", N);
        end
    endgenerate

`ifdef VECT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
    localparam logic LastOnData = 1'b0;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
    localparam logic LastOnData = 1'b1;
`endif

    state_e       state_q, state_d;
    logic [N-1:0] sh_q, sh_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic         accept;
`ifdef VECT_SERIALIZER_PARITY_EN
    logic         par_q, par_d;
`endif

    // Streaming window: idle, or the final bit of the frame is on the wire
    assign in_ready  = (state_q == StIdle) || last_q;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != StIdle);
    assign ser_out   = out_q;
    assign ser_valid = valid_q;
    assign ser_last  = last_q;

    // Next-state and next-output logic; outputs default to idle values
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
`ifdef VECT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // MSB goes straight to the output register; cnt counts bits still to come
            state_d = StShift;
            sh_d    = in_data;
            cnt_d   = 4'(N - 1);
            out_d   = in_data[N-1];
            valid_d = 1'b1;
            last_d  = LastOnData && (N == 1);
`ifdef VECT_SERIALIZER_PARITY_EN
            par_d   = ^in_data;
`endif
        end else begin
            case (state_q)
                StShift: begin
                    if (cnt_q != 4'd0) begin
                        sh_d    = sh_q << 1;
                        cnt_d   = cnt_q - 4'd1;
                        out_d   = sh_d[N-1];
                        valid_d = 1'b1;
                        last_d  = LastOnData && (cnt_q == 4'd1);
                    end else begin
`ifdef VECT_SERIALIZER_PARITY_EN
                        state_d = StParity;
                        out_d   = par_q;
                        valid_d = 1'b1;
                        last_d  = 1'b1;
`else
                        state_d = StIdle;
`endif
                    end
                end
`ifdef VECT_SERIALIZER_PARITY_EN
                StParity: state_d = StIdle;
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // State and registered outputs; reset aborts any frame in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sh_q    <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
`ifdef VECT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            last_q  <= last_d;
`ifdef VECT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_vect_serializer.sv
// Self-checking bench for vect_serializer (N=8 scoreboard, plus an N=1 instance).
// Follows VECT_SERIALIZER_PARITY_EN if defined for the build.
module tb_vect_serializer;

    localparam int N = 8;
`ifdef VECT_SERIALIZER_PARITY_EN
    localparam int FL = N + 1;
`else
    localparam int FL = N;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, ser_out, ser_valid, ser_last, busy;

    logic [0:0]   in_data1 = '0;
    logic         in_valid1 = 1'b0;
    logic         in_ready1, ser_out1, ser_valid1, ser_last1, busy1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] sb[$];  // {bit, last}

    always #5 clk = ~clk;

    vect_serializer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
        .ser_last(ser_last), .busy(busy)
    );

    vect_serializer #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .ser_last(ser_last1), .busy(busy1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Expected serial frame for one word
    task automatic push_word(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) begin
`ifdef VECT_SERIALIZER_PARITY_EN
            sb.push_back({w[i], 1'b0});
`else
            sb.push_back({w[i], i == 0});
`endif
        end
`ifdef VECT_SERIALIZER_PARITY_EN
        sb.push_back({^w, 1'b1});
`endif
    endtask

    // Offer a word until accepted; returns #1 after the accept edge
    task automatic send(input logic [N-1:0] w);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && waited < 4 * FL) begin
            @(posedge clk) #1;
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
        else push_word(w);
        @(posedge clk) #1;
        in_valid = 1'b0;
        in_data  = N'($urandom);  // must not disturb the frame in flight
    endtask

    task automatic drain();
        int waited = 0;
        while ((sb.size() != 0 || busy) && waited < 8 * FL) begin
            @(posedge clk) #1;
            waited++;
        end
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard monitor for the N=8 instance, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (ser_valid) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = sb.pop_front();
                    check_eq("ser_out", 32'(ser_out), 32'(e[1]));
                    check_eq("ser_last", 32'(ser_last), 32'(e[0]));
                end
            end else begin
                check_eq("idle_out", 32'(ser_out), 32'd0);
                check_eq("idle_last", 32'(ser_last), 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_valid", 32'(ser_valid), 32'd0);
        check_eq("rst_out", 32'(ser_out), 32'd0);
        check_eq("rst_last", 32'(ser_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk) #1;

        // Single frame 0xA5: busy and in_ready profile per cycle
        send(8'hA5);
        for (int c = 1; c <= FL; c++) begin
            check_eq("a5_busy", 32'(busy), 32'd1);
            check_eq("a5_valid", 32'(ser_valid), 32'd1);
            check_eq("a5_ready", 32'(in_ready), 32'(c == FL));
            @(posedge clk) #1;
        end
        check_eq("a5_end_busy", 32'(busy), 32'd0);
        check_eq("a5_end_valid", 32'(ser_valid), 32'd0);
        drain();

        // Zero-bubble streaming: 0xFF then 0x01 with in_valid held
        in_valid = 1'b1;
        in_data  = 8'hFF;
        push_word(8'hFF);
        @(posedge clk) #1;
        in_data = 8'h01;
        for (int c = 1; c <= 2 * FL; c++) begin
            if (c == FL + 1) in_valid = 1'b0;
            check_eq("str_valid", 32'(ser_valid), 32'd1);
            check_eq("str_ready", 32'(in_ready), 32'(c == FL || c == 2 * FL));
            check_eq("str_last", 32'(ser_last), 32'(c == FL || c == 2 * FL));
            if (c == FL) push_word(8'h01);
            @(posedge clk) #1;
        end
        check_eq("str_end_valid", 32'(ser_valid), 32'd0);
        drain();

        // Reset during the 4th bit of 0xC3
        send(8'hC3);
        repeat (3) @(posedge clk) #1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(ser_valid), 32'd0);
        check_eq("abort_out", 32'(ser_out), 32'd0);
        check_eq("abort_last", 32'(ser_last), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk) #1;
            check_eq("post_rst_valid", 32'(ser_valid), 32'd0);
            check_eq("post_rst_busy", 32'(busy), 32'd0);
        end
        send(8'h3C);
        drain();

        // Random words, with and without idle gaps between them
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk) #1;
            send(N'($urandom));
        end
        drain();

        // N=1 instance: single-bit frame
        in_valid1 = 1'b1;
        in_data1  = 1'b1;
        check_eq("n1_ready", 32'(in_ready1), 32'd1);
        @(posedge clk) #1;
        in_valid1 = 1'b0;
        in_data1  = 1'b0;
        check_eq("n1_out", 32'(ser_out1), 32'd1);
        check_eq("n1_valid", 32'(ser_valid1), 32'd1);
        check_eq("n1_busy", 32'(busy1), 32'd1);
`ifdef VECT_SERIALIZER_PARITY_EN
        check_eq("n1_last", 32'(ser_last1), 32'd0);
        @(posedge clk) #1;
        check_eq("n1_par_out", 32'(ser_out1), 32'd1);
        check_eq("n1_par_last", 32'(ser_last1), 32'd1);
`else
        check_eq("n1_last", 32'(ser_last1), 32'd1);
        check_eq("n1_ready_last", 32'(in_ready1), 32'd1);
`endif
        @(posedge clk) #1;
        check_eq("n1_end_valid", 32'(ser_valid1), 32'd0);
        check_eq("n1_end_out", 32'(ser_out1), 32'd0);
        check_eq("n1_end_busy", 32'(busy1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vect_serializer.md
VECT_SERIALIZER -- requirements
Module: vect_serializer

Interface
REQ-001 SHALL have parameter N, default 8, meaning data word width in bits.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_data, input, N, parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1, in_data is valid.
REQ-006 SHALL have port in_ready, output, 1, the block accepts a word this cycle.
REQ-007 SHALL have port ser_out, output, 1, serial bit, MSB first.
REQ-008 SHALL have port ser_valid, output, 1, ser_out carries a frame bit.
REQ-009 SHALL have port ser_last, output, 1, final bit of the current frame.
REQ-010 SHALL have port busy, output, 1, a frame is in progress (state not IDLE).

Function
REQ-011 SHALL raise an elaboration-time $error "Parameter N has an invalid value of <N>" when N<1 or N>8; no runtime check.
REQ-012 SHALL implement states IDLE, SHIFT and PARITY; PARITY is present only per REQ-024.
REQ-013 SHALL accept a word on the rising edge where in_valid && in_ready; no other edge has an accept.
REQ-014 SHALL drive in_ready combinationally high in IDLE and during the final bit cycle of a frame (ser_last=1); otherwise low.
REQ-015 SHALL, on accept, load the shift register and set the bit counter to N-1; state becomes SHIFT on the same edge.
REQ-016 SHALL register ser_out, ser_valid and ser_last; the first bit (in_data[N-1]) appears in the cycle after the accept edge (latency 1).
REQ-017 SHALL present bits in[N-1], in[N-2], ... in[0] on consecutive cycles with no gaps and no backpressure; ser_valid=1 for all N cycles.
REQ-018 SHALL assert ser_last only on the frame's final bit cycle; for N=1 the first bit is also the last bit.
REQ-019 SHALL, on accept during a last-bit cycle, start the next frame's MSB in the immediately following cycle (zero-bubble streaming); otherwise return to IDLE with ser_valid=0.
REQ-020 SHALL hold in_data sampling only at the accept edge; later changes to in_data SHALL NOT affect the frame in progress.
REQ-021 SHALL drive ser_out=0 whenever ser_valid=0.

Reset
REQ-022 SHALL, while rst_n=0, force state=IDLE, shift register=0, counter=0, ser_out=0, ser_valid=0, ser_last=0 and busy=0; in_ready becomes 1 as the combinational result of IDLE.
REQ-023 SHALL abort any frame in progress when reset asserts mid-frame; after release, no residual bits are emitted and the next accept starts a fresh frame.

Configuration
REQ-024 SHALL, when VECT_SERIALIZER_PARITY_EN is defined, append one even-parity bit (XOR of the accepted word) in state PARITY after bit 0.
- In this mode ser_last and the in_ready streaming window move to the parity cycle.
- The frame is N+1 cycles long.
REQ-025 SHALL, when VECT_SERIALIZER_PARITY_EN is undefined, contain no PARITY state or parity logic, and frames are N cycles long.

Verification
REQ-026 SHALL cover: N=8, accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8 after the accept, ser_last on cycle 8 only, busy high for 8 cycles.
REQ-027 SHALL cover: N=8, 8'hFF then 8'h01 with in_valid held high -> 16 contiguous ser_valid cycles, ser_last on cycles 8 and 16, in_ready high only on cycles 8 and 16.
REQ-028 SHALL cover: N=1, accept 1'b1 -> a single cycle with ser_out=1, ser_valid=1, ser_last=1; then IDLE.
REQ-029 SHALL cover: N=8, accept 8'hC3, assert rst_n=0 on the 4th bit cycle -> outputs go 0 asynchronously; after release ser_valid stays 0 until a new accept.
REQ-030 SHALL cover: VECT_SERIALIZER_PARITY_EN defined, N=4, accept 4'b1011 -> bits 1,0,1,1 then parity bit 1, with ser_last on the parity bit.
REQ-031 SHALL cover: elaborating with N=0 and with N=9 -> elaboration $error reporting the value.
